tx_arbiter: RTL and testbench
=============================

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, the number of requesters sharing one serial transmitter (2..8).
REQ-002 SHALL have parameter MAX_BURST, default 4, the maximum number of consecutive bytes one grant may send (1..15).
REQ-003 SHALL have parameter START_TIMEOUT, default 15, the maximum sys_clk cycles allowed between tx_wr and tx_busy rising.
REQ-004 SHALL have port sys_clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port req, input, N_REQ bits: per-requester level request, bit i = requester i has a byte pending.
REQ-007 SHALL have port data, input, 8*N_REQ bits: requester i byte on data[8i+7:8i], held stable while req[i] is high.
REQ-008 SHALL have port ack, output, N_REQ bits: one-cycle one-hot pulse; requester i's byte was accepted by the transmitter.
REQ-009 SHALL have port grant, output, N_REQ bits: one-hot current owner, zero when idle.
REQ-010 SHALL have port tx_data, output, 8 bits: byte presented to the transmitter.
REQ-011 SHALL have port tx_wr, output, 1 bit: one-cycle start strobe to the transmitter.
REQ-012 SHALL have port tx_busy, input, 1 bit: transmitter frame in progress.
REQ-013 SHALL have port err, output, 1 bit: sticky; transmitter failed to start within START_TIMEOUT.

Function
REQ-014 SHALL implement FSM states IDLE, ARB, START, WAIT_BUSY, WAIT_DONE.
REQ-015 In IDLE with req nonzero and tx_busy low, SHALL go to ARB next cycle; otherwise stays in IDLE.
REQ-016 ARB SHALL pick the first asserted req at or after index (last_owner+1) mod N_REQ, set grant, latch that byte into tx_data, clear burst count, go to START.
REQ-017 START SHALL assert tx_wr for exactly one cycle, increment burst count, go to WAIT_BUSY.
REQ-018 WAIT_BUSY SHALL go to WAIT_DONE on tx_busy high, pulsing ack for the owner in that same cycle.
REQ-019 If tx_busy stays low START_TIMEOUT cycles in WAIT_BUSY, SHALL set err, drop grant, give no ack, go to IDLE.
REQ-020 WAIT_DONE on tx_busy low: if owner's req still high and burst count < MAX_BURST, SHALL relatch data and go to START; else SHALL record last_owner, drop grant, go to IDLE.
REQ-021 A requester dropping req mid-frame SHALL NOT abort the frame; only the burst ends.
REQ-022 Requests arriving during a grant SHALL wait; round-robin SHALL guarantee every requester a grant within N_REQ grants.
REQ-023 tx_data SHALL remain stable from START through WAIT_DONE.
REQ-024 Burst counter SHALL be 4 bits and saturate, never wrap.
REQ-025 err SHALL clear only on reset.

Reset
REQ-026 On rst_n low, SHALL immediately set state IDLE, grant 0, ack 0, tx_wr 0, tx_data 0x00, err 0, burst count 0, and last_owner N_REQ-1 so that requester 0 wins first.
REQ-027 Reset mid-frame SHALL abandon the transfer without issuing ack.

Structure
REQ-028 State encodings, default N_REQ/MAX_BURST/START_TIMEOUT and the 8-bit byte width SHALL live in shared package uart_pkg.
REQ-029 The round-robin selector SHALL be sub-module rr_pick (inputs req and last_owner; outputs one-hot winner and index), purely combinational.

Verification
REQ-030 Single requester: req=0001, data0="K"; tx_busy high 2 cycles after tx_wr for 10 cycles -> one tx_wr, tx_data=0x4B, ack=0001 once.
REQ-031 Contention: req=1111 held, each data distinct, MAX_BURST=1 -> grant order 0,1,2,3,0 and ack pulses in that order.
REQ-032 Burst: req0 held 6 frames, MAX_BURST=4 -> 4 consecutive frames from 0, then grant passes to waiting req2, then 0 resumes.
REQ-033 Timeout: tx_busy tied low -> err=1 on cycle START_TIMEOUT after tx_wr, no ack, grant=0, next request still arbitrated.
REQ-034 Reset mid-frame: rst_n low during WAIT_DONE -> all outputs zero same cycle, no ack; after release requester 0 wins first.
REQ-035 Bench SHALL pair tx_arbiter with baud_gen (CLK_FREQ 48, BIT_FREQ 5) and serial_tx, and check the serial line decodes to the acked bytes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared widths, defaults and FSM encoding for the serial transmit arbiter
// and the small UART transmitter it feeds.
package uart_pkg;
    localparam int BYTE_W            = 8;
    localparam int N_REQ_DEF         = 4;
    localparam int MAX_BURST_DEF     = 4;
    localparam int START_TIMEOUT_DEF = 15;
    localparam int BURST_W           = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARB       = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/baud_gen.sv
// Fractional bit-rate tick generator: one-cycle tick at BIT_FREQ/CLK_FREQ
// average rate using a phase accumulator.
module baud_gen #(
    parameter int CLK_FREQ = 48,
    parameter int BIT_FREQ = 5
) (
    input  logic sys_clk,
    input  logic rst_n,
    output logic tick
);
    localparam int ACC_W = $clog2(CLK_FREQ + BIT_FREQ + 1);

    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic             tick_q, tick_d;

    always_comb begin
        sum    = acc_q + ACC_W'(BIT_FREQ);
        acc_d  = sum;
        tick_d = 1'b0;
        if (sum >= ACC_W'(CLK_FREQ)) begin
            acc_d  = sum - ACC_W'(CLK_FREQ);
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
endmodule

// File: rtl/rr_pick.sv
// Round-robin selector: first asserted request strictly after last_owner,
// wrapping; purely combinational.
module rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_owner,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] win_idx
);
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        winner  = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last_owner) + k) % N_REQ);
            if (!found && req[cand]) begin
                found        = 1'b1;
                winner[cand] = 1'b1;
                win_idx      = cand;
            end
        end
    end
endmodule

// File: rtl/serial_tx.sv
// 8N1 serial transmitter: start bit on tx_wr, then LSB-first data and a stop
// bit, each held one tick; busy stays high until the stop bit has elapsed.
module serial_tx
    import uart_pkg::*;
(
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              tx_wr,
    input  logic [BYTE_W-1:0] tx_data,
    output logic              tx_busy,
    output logic              txd
);
    logic            busy_q, busy_d;
    logic [BYTE_W:0] shift_q, shift_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            txd_q, txd_d;

    always_comb begin
        busy_d  = busy_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        txd_d   = txd_q;
        if (!busy_q) begin
            if (tx_wr) begin
                busy_d  = 1'b1;
                shift_d = {1'b1, tx_data};
                txd_d   = 1'b0;
                cnt_d   = '0;
            end
        end else if (tick) begin
            // cnt 9 means the stop bit has been on the line for a full tick
            if (cnt_q == 4'd9) begin
                busy_d = 1'b0;
            end else begin
                txd_d   = shift_q[0];
                shift_d = {1'b1, shift_q[BYTE_W:1]};
                cnt_d   = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            shift_q <= '1;
            cnt_q   <= '0;
            txd_q   <= 1'b1;
        end else begin
            busy_q  <= busy_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            txd_q   <= txd_d;
        end
    end

    assign tx_busy = busy_q;
    assign txd     = txd_q;
endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one serial transmitter among N_REQ byte
// sources, with bounded bursts and a sticky start-timeout error.
module tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ         = N_REQ_DEF,
    parameter int MAX_BURST     = MAX_BURST_DEF,
    parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [BYTE_W*N_REQ-1:0] data,
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        grant,
    output logic [BYTE_W-1:0]       tx_data,
    output logic                    tx_wr,
    input  logic                    tx_busy,
    output logic                    err
);
    localparam int                 IDX_W     = idx_w(N_REQ);
    localparam int                 TMO_W     = $clog2(START_TIMEOUT + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(START_TIMEOUT - 1);

    arb_state_e         state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_owner_q, last_owner_d;
    logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               err_q, err_d;

    logic [N_REQ-1:0]   win;
    logic [IDX_W-1:0]   win_idx;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req        (req),
        .last_owner (last_owner_q),
        .winner     (win),
        .win_idx    (win_idx)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        tx_data_d    = tx_data_q;
        burst_d      = burst_q;
        tmo_d        = tmo_q;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                if (|req && !tx_busy) state_d = ST_ARB;
            end
            ST_ARB: begin
                // a request withdrawn during the ARB cycle just returns to idle
                if (|win) begin
                    grant_d   = win;
                    owner_d   = win_idx;
                    tx_data_d = data[win_idx*BYTE_W +: BYTE_W];
                    burst_d   = '0;
                    state_d   = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (burst_q != '1) burst_d = burst_q + BURST_W'(1);
                // tmo counts cycles since tx_wr, so err lands START_TIMEOUT cycles after it
                tmo_d   = TMO_W'(1);
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_q >= TMO_LAST) begin
                    // owner is rotated past so a dead requester cannot starve the rest
                    err_d        = 1'b1;
                    grant_d      = '0;
                    last_owner_d = owner_q;
                    state_d      = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (req[owner_q] && (burst_q < BURST_MAX)) begin
                        tx_data_d = data[owner_q*BYTE_W +: BYTE_W];
                        state_d   = ST_START;
                    end else begin
                        last_owner_d = owner_q;
                        grant_d      = '0;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(N_REQ - 1);
            tx_data_q    <= '0;
            burst_q      <= '0;
            tmo_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            tx_data_q    <= tx_data_d;
            burst_q      <= burst_d;
            tmo_q        <= tmo_d;
            err_q        <= err_d;
        end
    end

    assign grant   = grant_q;
    assign tx_data = tx_data_q;
    assign tx_wr   = (state_q == ST_START);
    assign ack     = (state_q == ST_WAIT_BUSY && tx_busy) ? grant_q : '0;
    assign err     = err_q;
endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench: two arbiters (MAX_BURST 4 and 1) with a simple busy
// responder, plus a baud_gen/serial_tx path whose line is decoded back.
module tb_tx_arbiter;
    localparam logic [31:0] BASE = {8'hD3, 8'hC0, 8'hA1, 8'h4B};

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b1;
    logic [3:0]  req0, req1;
    logic [31:0] data0, data1;
    logic [3:0]  ack0, ack1, grant0, grant1;
    logic [7:0]  tx_data0, tx_data1;
    logic        tx_wr0, tx_wr1, busy0, busy1, err0, err1;
    logic        rsp_en0 = 1'b1;
    logic        use_ser = 1'b0;
    logic        rsp_busy0, btick, ser_busy, txd;

    int load0  [4] = '{0, 0, 0, 0};
    int acked0 [4] = '{0, 0, 0, 0};
    int rsp_cnt0 = 0, rsp_cnt1 = 0;
    int wr_cnt0 = 0, wr_cnt1 = 0;
    logic [11:0] ack_log0 [$];
    logic [11:0] ack_log1 [$];
    logic [7:0]  rx_log [$];
    logic        rx_act = 1'b0;
    int          rx_cnt = 0, rx_ferr = 0;
    logic [7:0]  rx_sh = '0;
    int n_assert = 0, n_fail = 0;
    int rd0 = 0, rd1 = 0, rdx = 0;

    always #5 sys_clk = ~sys_clk;

    tx_arbiter u_dut0 (
        .sys_clk (sys_clk), .rst_n (rst_n), .req (req0), .data (data0),
        .ack (ack0), .grant (grant0), .tx_data (tx_data0), .tx_wr (tx_wr0),
        .tx_busy (busy0), .err (err0)
    );

    tx_arbiter #(.N_REQ(4), .MAX_BURST(1), .START_TIMEOUT(15)) u_dut1 (
        .sys_clk (sys_clk), .rst_n (rst_n), .req (req1), .data (data1),
        .ack (ack1), .grant (grant1), .tx_data (tx_data1), .tx_wr (tx_wr1),
        .tx_busy (busy1), .err (err1)
    );

    baud_gen #(.CLK_FREQ(48), .BIT_FREQ(5)) u_baud (
        .sys_clk (sys_clk), .rst_n (rst_n), .tick (btick)
    );

    serial_tx u_ser (
        .sys_clk (sys_clk), .rst_n (rst_n), .tick (btick),
        .tx_wr (tx_wr0 & use_ser), .tx_data (tx_data0),
        .tx_busy (ser_busy), .txd (txd)
    );

    // Transmitter stand-in: busy rises 2 cycles after tx_wr, stays 10 cycles
    always @(posedge sys_clk) begin
        if (rsp_cnt0 != 0) rsp_cnt0 <= (rsp_cnt0 == 11) ? 0 : rsp_cnt0 + 1;
        else if (tx_wr0 && rsp_en0) rsp_cnt0 <= 1;
        if (rsp_cnt1 != 0) rsp_cnt1 <= (rsp_cnt1 == 11) ? 0 : rsp_cnt1 + 1;
        else if (tx_wr1) rsp_cnt1 <= 1;
    end
    assign rsp_busy0 = rsp_en0 && (rsp_cnt0 >= 2);
    assign busy0     = use_ser ? ser_busy : rsp_busy0;
    assign busy1     = (rsp_cnt1 >= 2);

    // Requesters on dut0: each holds req while it still has bytes queued
    always_comb begin
        req0  = '0;
        data0 = '0;
        for (int i = 0; i < 4; i++) begin
            req0[i]         = (acked0[i] < load0[i]);
            data0[8*i +: 8] = BASE[8*i +: 8] + 8'(acked0[i]);
        end
    end

    always @(posedge sys_clk) begin
        for (int i = 0; i < 4; i++)
            if (ack0[i]) acked0[i] <= acked0[i] + 1;
        if (ack0 != 0) ack_log0.push_back({ack0, tx_data0});
        if (ack1 != 0) ack_log1.push_back({ack1, tx_data1});
        if (tx_wr0) wr_cnt0 <= wr_cnt0 + 1;
        if (tx_wr1) wr_cnt1 <= wr_cnt1 + 1;
    end

    // Line decoder, bit boundaries taken from the baud tick
    always @(posedge sys_clk) begin
        if (rx_act || !txd) begin
            rx_act <= 1'b1;
            if (btick) begin
                if (rx_cnt == 0) begin
                    if (txd) rx_ferr <= rx_ferr + 1;
                end else if (rx_cnt <= 8) begin
                    rx_sh <= {txd, rx_sh[7:1]};
                end else begin
                    if (!txd) rx_ferr <= rx_ferr + 1;
                    rx_log.push_back(rx_sh);
                    rx_act <= 1'b0;
                end
                rx_cnt <= (rx_cnt == 9) ? 0 : rx_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic chk_ack0(input string tag, input logic [11:0] exp);
        logic [11:0] got;
        got = (ack_log0.size() > rd0) ? ack_log0[rd0] : 12'hxxx;
        rd0++;
        check(tag, 32'(got), 32'(exp));
    endtask

    task automatic chk_ack1(input string tag, input logic [11:0] exp);
        logic [11:0] got;
        got = (ack_log1.size() > rd1) ? ack_log1[rd1] : 12'hxxx;
        rd1++;
        check(tag, 32'(got), 32'(exp));
    endtask

    task automatic chk_rx(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = (rx_log.size() > rdx) ? rx_log[rdx] : 8'hxx;
        rdx++;
        check(tag, 32'(got), 32'(exp));
    endtask

    initial begin
        req1  = '0;
        data1 = {8'h44, 8'h33, 8'h22, 8'h11};

        // reset acts without a clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst_grant",   32'(grant0),   32'h0);
        check("rst_ack",     32'(ack0),     32'h0);
        check("rst_tx_wr",   32'(tx_wr0),   32'h0);
        check("rst_tx_data", 32'(tx_data0), 32'h00);
        check("rst_err",     32'(err0),     32'h0);
        check("rst_grant1",  32'(grant1),   32'h0);
        step(2);
        rst_n = 1'b1;
        step(2);

        // single requester, 'K'
        load0[0] = 1;
        step(2);
        check("single_tx_wr",   32'(tx_wr0),   32'h1);
        check("single_grant",   32'(grant0),   32'h1);
        check("single_tx_data", 32'(tx_data0), 32'h4B);
        step(1);
        check("single_wr_1cyc", 32'(tx_wr0),   32'h0);
        step(1);
        check("single_ack",     32'(ack0),     32'h1);
        step(30);
        check("single_grant_off", 32'(grant0), 32'h0);
        check("single_wr_cnt",    32'(wr_cnt0), 32'd1);
        chk_ack0("single_log", {4'b0001, 8'h4B});
        check("single_nacks", 32'(ack_log0.size()), 32'd1);

        // contention on MAX_BURST=1 instance
        req1 = 4'hF;
        step(70);
        req1 = 4'h0;
        step(15);
        chk_ack1("rr_0", {4'b0001, 8'h11});
        chk_ack1("rr_1", {4'b0010, 8'h22});
        chk_ack1("rr_2", {4'b0100, 8'h33});
        chk_ack1("rr_3", {4'b1000, 8'h44});
        chk_ack1("rr_4", {4'b0001, 8'h11});
        check("rr_nacks",  32'(ack_log1.size()), 32'd5);
        check("rr_wr_cnt", 32'(wr_cnt1), 32'd5);

        // burst of 6 from req0, req2 arrives during the first grant
        load0[0] = 7;
        step(5);
        load0[2] = 1;
        step(150);
        chk_ack0("burst_0", {4'b0001, 8'h4C});
        chk_ack0("burst_1", {4'b0001, 8'h4D});
        chk_ack0("burst_2", {4'b0001, 8'h4E});
        chk_ack0("burst_3", {4'b0001, 8'h4F});
        chk_ack0("burst_r2", {4'b0100, 8'hC0});
        chk_ack0("burst_4", {4'b0001, 8'h50});
        chk_ack0("burst_5", {4'b0001, 8'h51});
        check("burst_nacks", 32'(ack_log0.size()), 32'd8);
        check("burst_grant_off", 32'(grant0), 32'h0);

        // start timeout with busy held low
        rsp_en0  = 1'b0;
        load0[1] = 1;
        step(16);
        check("tmo_err_early", 32'(err0),   32'h0);
        check("tmo_grant_hold", 32'(grant0), 32'h2);
        step(1);
        check("tmo_err",       32'(err0),   32'h1);
        check("tmo_grant_off", 32'(grant0), 32'h0);
        check("tmo_no_ack",    32'(ack_log0.size()), 32'd8);
        rsp_en0 = 1'b1;
        step(40);
        chk_ack0("tmo_retry", {4'b0010, 8'hA1});
        check("tmo_err_sticky", 32'(err0),   32'h1);
        check("tmo_wr_cnt",     32'(wr_cnt0), 32'd10);

        // reset during WAIT_DONE
        load0[3] = 1;
        step(6);
        rst_n = 1'b0;
        #1;
        check("mrst_grant",   32'(grant0),   32'h0);
        check("mrst_ack",     32'(ack0),     32'h0);
        check("mrst_tx_wr",   32'(tx_wr0),   32'h0);
        check("mrst_tx_data", 32'(tx_data0), 32'h00);
        check("mrst_err",     32'(err0),     32'h0);
        chk_ack0("mrst_pre_ack", {4'b1000, 8'hD3});
        step(2);
        rst_n = 1'b1;
        load0[0] = 8;
        load0[2] = 2;
        step(60);
        chk_ack0("mrst_first", {4'b0001, 8'h52});
        chk_ack0("mrst_second", {4'b0100, 8'hC1});
        check("mrst_nacks", 32'(ack_log0.size()), 32'd12);

        // serial path: decoded line must match acked bytes
        use_ser  = 1'b1;
        load0[1] = 2;
        load0[3] = 2;
        step(320);
        chk_ack0("ser_ack_0", {4'b1000, 8'hD4});
        chk_ack0("ser_ack_1", {4'b0010, 8'hA2});
        chk_rx("ser_rx_0", 8'hD4);
        chk_rx("ser_rx_1", 8'hA2);
        check("ser_rx_n",   32'(rx_log.size()), 32'd2);
        check("ser_framing", 32'(rx_ferr), 32'd0);
        check("ser_err",    32'(err0), 32'h0);
        check("dut1_err",   32'(err1), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
